dma_rd: RTL and testbench

DMA_RD -- requirements
Module: dma_rd

---
 rtl/dma_rd_pkg.sv | 32 +++
 rtl/dma_rd.sv | 83 ++++++++
 tb/tb_dma_rd.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_rd_pkg.sv
// Shared DMA state encodings: the sample-writer DMA and the SPI read-out DMA
// keep their enums side by side here under distinct prefixes.
package dma_rd_pkg;

   typedef enum logic [3:0] {
      DMA_WR_IDLE  = 4'h0,
      DMA_WR_WAIT  = 4'h1,
      DMA_WR_WRITE = 4'h2,
      DMA_WR_DONE  = 4'h3
   } dma_wr_state_t;

   // Four bits leave unused codes so a corrupted state register can be detected.
   typedef enum logic [3:0] {
      DMA_RD_IDLE    = 4'h0,
      DMA_RD_REQ     = 4'h1,
      DMA_RD_STROBE  = 4'h2,
      DMA_RD_SAMPLE  = 4'h3,
      DMA_RD_RELEASE = 4'h4,
      DMA_RD_TX_WAIT = 4'h5,
      DMA_RD_TX_LOAD = 4'h6,
      DMA_RD_INCR    = 4'h7
   } dma_rd_state_t;

   function automatic logic rd_holds_bus(dma_rd_state_t s);
      return (s == DMA_RD_REQ) || (s == DMA_RD_STROBE) || (s == DMA_RD_SAMPLE);
   endfunction

   function automatic logic rd_strobes(dma_rd_state_t s);
      return (s == DMA_RD_STROBE) || (s == DMA_RD_SAMPLE);
   endfunction

endpackage

// File: rtl/dma_rd.sv
// Read-side DMA: streams one filled buffer half from memory into the SPI
// transmitter, re-arbitrating for the bus on every byte.
module dma_rd
   import dma_rd_pkg::*;
#(
   parameter int HALF_LEN = 128,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              buf_rdy,
   input  logic              buf_half,
   input  logic              bgrant,
   input  logic [7:0]        d,
   input  logic              tx_busy,
   output logic              breq,
   output logic              as,
   output logic              write,
   output logic [ADDR_W-1:0] a,
   output logic              load_spi,
   output logic [7:0]        spi_data,
   output logic              done,
   output logic              overrun,
   output logic [3:0]        state_dbg
);

   localparam logic [ADDR_W-2:0] LAST_OFS = (ADDR_W-1)'(HALF_LEN - 1);

   dma_rd_state_t state;
   dma_rd_state_t next;
   logic          last;

   assign last      = (a[ADDR_W-2:0] == LAST_OFS);
   assign state_dbg = state;

   always_comb begin
      next = DMA_RD_IDLE;
      case (state)
         DMA_RD_IDLE:    next = buf_rdy ? DMA_RD_REQ : DMA_RD_IDLE;
         DMA_RD_REQ:     next = bgrant ? DMA_RD_STROBE : DMA_RD_REQ;
         DMA_RD_STROBE:  next = DMA_RD_SAMPLE;
         DMA_RD_SAMPLE:  next = DMA_RD_RELEASE;
         DMA_RD_RELEASE: next = DMA_RD_TX_WAIT;
         DMA_RD_TX_WAIT: next = tx_busy ? DMA_RD_TX_WAIT : DMA_RD_TX_LOAD;
         DMA_RD_TX_LOAD: next = DMA_RD_INCR;
         DMA_RD_INCR:    next = last ? DMA_RD_IDLE : DMA_RD_REQ;
         default:        next = DMA_RD_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so each registered output is
   // high exactly while the FSM sits in the matching state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= DMA_RD_IDLE;
         breq     <= 1'b0;
         as       <= 1'b0;
         write    <= 1'b0;
         a        <= '0;
         load_spi <= 1'b0;
         spi_data <= 8'h00;
         done     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= next;
         breq     <= rd_holds_bus(next);
         as       <= rd_strobes(next);
         write    <= 1'b0;
         load_spi <= (next == DMA_RD_TX_LOAD);
         done     <= (state == DMA_RD_INCR) && last;
         if (state == DMA_RD_IDLE && buf_rdy)
            a <= {buf_half, {(ADDR_W-1){1'b0}}};
         else if (state == DMA_RD_INCR && !last)
            a <= a + ADDR_W'(1);
         if (state == DMA_RD_SAMPLE)
            spi_data <= d;
         // A new half arriving while one is in flight is reported, never queued.
         if (buf_rdy && state != DMA_RD_IDLE)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_rd.sv
// Directed bench for dma_rd: a table of transfer scenarios plus reset and
// protocol checks, with memory modelled as d = a.
module tb_dma_rd;
   import dma_rd_pkg::*;

   localparam int HALF = 128;

   logic       clk;
   logic       reset;
   logic       buf_rdy;
   logic       buf_half;
   logic       bgrant;
   logic [7:0] d;
   logic       tx_busy;
   logic       breq;
   logic       as;
   logic       write;
   logic [7:0] a;
   logic       load_spi;
   logic [7:0] spi_data;
   logic       done;
   logic       overrun;
   logic [3:0] state_dbg;

   dma_rd #(.HALF_LEN(HALF), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .buf_rdy(buf_rdy), .buf_half(buf_half),
      .bgrant(bgrant), .d(d), .tx_busy(tx_busy), .breq(breq), .as(as),
      .write(write), .a(a), .load_spi(load_spi), .spi_data(spi_data),
      .done(done), .overrun(overrun), .state_dbg(state_dbg)
   );

   assign d = a;

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // bus arbiter model: grants after grant_dly cycles of continuous request
   int grant_dly = 0;
   int wait_cnt  = 0;
   initial begin
      bgrant = 1'b0;
      forever begin
         @(negedge clk);
         if (!breq) begin
            wait_cnt = 0;
            bgrant   = (grant_dly == 0);
         end else begin
            bgrant = (wait_cnt >= grant_dly);
            wait_cnt++;
         end
      end
   end

   // scoreboard and protocol monitor
   int   load_cnt  = 0;
   int   done_cnt  = 0;
   int   prot_err  = 0;
   int   lat_err   = 0;
   int   cyc       = 0;
   int   grant_cyc = 0;
   bit   lat_en    = 1'b1;
   logic p_breq, p_as, p_bgrant;
   logic [7:0] exp_b;

   always @(posedge clk) begin
      p_breq   = breq;
      p_as     = as;
      p_bgrant = bgrant;
      #1;
      cyc++;
      if (p_breq && p_bgrant && !p_as) grant_cyc = cyc;
      if (reset) begin
         if (as && !breq) prot_err++;
         if (as && !p_as && !(p_breq && p_bgrant)) prot_err++;
         if (p_as && !as && breq) prot_err++;
         if (p_breq && !p_as && !p_bgrant && !breq) prot_err++;
         if (write) prot_err++;
         if (load_spi && tx_busy) prot_err++;
         if (load_spi) begin
            load_cnt++;
            if (lat_en && (cyc - grant_cyc) != 4) lat_err++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_load: got byte %0h expected no load", spi_data);
            end else begin
               exp_b = exp_q.pop_front();
               chk("spi_data", spi_data, exp_b);
            end
         end
         if (done) begin
            done_cnt++;
            chk("bytes_left_at_done", exp_q.size(), 0);
         end
      end
   end

   typedef struct {
      string      name;
      logic       half;
      int         grant_dly;
      int         busy_cyc;
      int         second_at;
      int         reset_at;
      bit         chain;
      int         exp_loads;
      int         exp_done;
      logic       exp_ovr;
      logic [7:0] exp_a;
   } vec_t;

   vec_t vecs[7];

   task automatic push_half(input logic half, input int n);
      logic [7:0] base;
      base = half ? 8'h80 : 8'h00;
      for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
   endtask

   // driver for one table scenario
   task automatic run_case(input vec_t v);
      int l0, d0, p0, t0, busy_left;
      bit sent2, busy_started, chained, finished;
      busy_left = 0; sent2 = 0; busy_started = 0; chained = 0; finished = 0;
      grant_dly = v.grant_dly;
      lat_en    = (v.busy_cyc == 0);
      tx_busy   = 1'b0;
      exp_q.delete();
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      l0 = load_cnt; d0 = done_cnt; p0 = prot_err; t0 = lat_err;
      push_half(v.half, (v.reset_at > 0) ? v.reset_at : HALF);
      buf_half = v.half;
      buf_rdy  = 1'b1;
      for (int c = 0; c < 4000 && !finished; c++) begin
         @(negedge clk);
         buf_rdy = 1'b0;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               chk({v.name, "_busy_hold"}, {state_dbg, breq, load_spi},
                   {4'(DMA_RD_TX_WAIT), 2'b00});
               tx_busy = 1'b0;
            end
         end
         if (v.busy_cyc > 0 && !busy_started && load_cnt - l0 == 1) begin
            tx_busy      = 1'b1;
            busy_left    = v.busy_cyc;
            busy_started = 1'b1;
         end
         if (v.second_at > 0 && !sent2 && load_cnt - l0 == v.second_at) begin
            buf_half = ~v.half;
            buf_rdy  = 1'b1;
            sent2    = 1'b1;
         end
         if (v.chain && !chained && done_cnt - d0 == 1) begin
            buf_half = ~v.half;
            buf_rdy  = 1'b1;
            chained  = 1'b1;
            push_half(~v.half, HALF);
         end
         if (v.reset_at > 0 && load_cnt - l0 == v.reset_at) finished = 1'b1;
         if (v.reset_at == 0 && done_cnt - d0 == v.exp_done) finished = 1'b1;
      end
      chk({v.name, "_reached_end"}, finished, 1);
      if (v.reset_at > 0) begin
         reset = 1'b0;
         #1;
         chk({v.name, "_async_reset_outputs"},
             {breq, as, write, a, load_spi, spi_data, done, overrun}, 0);
         chk({v.name, "_async_reset_state"}, state_dbg, 4'(DMA_RD_IDLE));
         @(negedge clk); @(negedge clk);
         reset = 1'b1;
      end
      repeat (40) @(negedge clk);
      chk({v.name, "_loads"}, load_cnt - l0, v.exp_loads);
      chk({v.name, "_done_pulses"}, done_cnt - d0, v.exp_done);
      chk({v.name, "_overrun"}, overrun, v.exp_ovr);
      chk({v.name, "_final_addr"}, a, v.exp_a);
      chk({v.name, "_idle"}, state_dbg, 4'(DMA_RD_IDLE));
      chk({v.name, "_queue_empty"}, exp_q.size(), 0);
      chk({v.name, "_protocol_errs"}, prot_err - p0, 0);
      chk({v.name, "_latency_errs"}, lat_err - t0, 0);
   endtask

   initial begin
      vecs[0] = '{"half0",      1'b0, 0,  0,  0, 0,  1'b0, 128, 1, 1'b0, 8'h7F};
      vecs[1] = '{"half1",      1'b1, 0,  0,  0, 0,  1'b0, 128, 1, 1'b0, 8'hFF};
      vecs[2] = '{"grant_wait", 1'b0, 10, 0,  0, 0,  1'b0, 128, 1, 1'b0, 8'h7F};
      vecs[3] = '{"tx_busy",    1'b1, 0,  20, 0, 0,  1'b0, 128, 1, 1'b0, 8'hFF};
      vecs[4] = '{"overrun",    1'b0, 0,  0,  5, 0,  1'b0, 128, 1, 1'b1, 8'h7F};
      vecs[5] = '{"reset_mid",  1'b1, 0,  0,  0, 40, 1'b0, 40,  0, 1'b0, 8'h00};
      vecs[6] = '{"chain_done", 1'b1, 0,  0,  0, 0,  1'b1, 256, 2, 1'b0, 8'h7F};

      reset    = 1'b0;
      buf_rdy  = 1'b0;
      buf_half = 1'b0;
      tx_busy  = 1'b0;
      #2;
      chk("rst_breq", breq, 0);
      chk("rst_as", as, 0);
      chk("rst_write", write, 0);
      chk("rst_a", a, 0);
      chk("rst_load_spi", load_spi, 0);
      chk("rst_spi_data", spi_data, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_state", state_dbg, 4'(DMA_RD_IDLE));

      // idle with no buf_rdy must stay quiet
      @(negedge clk); reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_no_req", {breq, as, load_spi, done}, 0);

      for (int i = 0; i < 7; i++) run_case(vecs[i]);

      // overrun stays set until reset even across a fresh transfer
      @(negedge clk);
      buf_rdy = 1'b1; buf_half = 1'b0;
      @(negedge clk); buf_rdy = 1'b1;
      @(negedge clk); buf_rdy = 1'b0;
      chk("overrun_set_late", overrun, 1);
      exp_q.delete();
      reset = 1'b0;
      #1;
      chk("overrun_cleared_by_reset", overrun, 0);
      @(negedge clk); reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_activity_after_reset", {breq, load_spi, done}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
